serial_magnitude_comparator_ctrl: RTL and testbench

- Sequences a 1-bit comparator slice MSB-first over two WIDTH-bit unsigned operands, one bit per clock, and produces registered lt/gt/eq flags.
- Accepts operand pairs through a valid/ready input handshake and holds the result behind a valid/ready output handshake.
- Intended as the area-minimal magnitude compare in the comparator family: one comparator slice, reused over time.

---
 rtl/serial_magnitude_comparator_ctrl.sv | 87 ++++++++
 tb/tb_serial_magnitude_comparator_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator_ctrl.sv
// serial_magnitude_comparator_ctrl: bit-serial MSB-first unsigned magnitude compare with valid/ready handshakes
// Ports: clk, rst (sync, active-high); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with result flags lt, gt, eq; busy while comparing.
module serial_magnitude_comparator_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic             busy
);
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
    state_t         state;
    logic [IW-1:0]  idx;
    logic [WIDTH-1:0] a_r, b_r;
    logic           diff;
    logic           ba, ne;
    assign ba       = a_r[idx];
    assign ne       = ba ^ b_r[idx];
    assign in_ready = (state == IDLE) && !rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= IW'(WIDTH - 1);
            a_r       <= '0;
            b_r       <= '0;
            diff      <= 1'b0;
            out_valid <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= b;
                    idx   <= IW'(WIDTH - 1);
                    diff  <= 1'b0;
                    lt    <= 1'b0;
                    gt    <= 1'b0;
                    eq    <= 1'b0;
                    busy  <= 1'b1;
                    state <= CMP;
                end
                CMP: begin
                    if (EARLY_EXIT && ne) begin
                        lt        <= !ba;
                        gt        <= ba;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (idx == '0) begin
                        // diff is still clear here if bit 0 is the first difference
                        eq        <= !diff && !ne;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                    // full-walk mode: only the most significant difference decides
                    if (!EARLY_EXIT && !diff && ne) begin
                        lt   <= !ba;
                        gt   <= ba;
                        diff <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_magnitude_comparator_ctrl.sv
// tb_serial_magnitude_comparator_ctrl: directed checks of the serial comparator in both exit modes
module tb_serial_magnitude_comparator_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ordy = 1'b1;
    logic iv8 = 1'b0, iv4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic ir8e, ov8e, lt8e, gt8e, eq8e, bz8e;
    logic ir8n, ov8n, lt8n, gt8n, eq8n, bz8n;
    logic ir4e, ov4e, lt4e, gt4e, eq4e, bz4e;
    logic ir4n, ov4n, lt4n, gt4n, eq4n, bz4n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u8e (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8e), .a(a8), .b(b8),
        .out_valid(ov8e), .out_ready(ordy), .lt(lt8e), .gt(gt8e), .eq(eq8e), .busy(bz8e));
    serial_magnitude_comparator_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u8n (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8n), .a(a8), .b(b8),
        .out_valid(ov8n), .out_ready(ordy), .lt(lt8n), .gt(gt8n), .eq(eq8n), .busy(bz8n));
    serial_magnitude_comparator_ctrl #(.WIDTH(4), .EARLY_EXIT(1'b1)) u4e (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4e), .a(a4), .b(b4),
        .out_valid(ov4e), .out_ready(ordy), .lt(lt4e), .gt(gt4e), .eq(eq4e), .busy(bz4e));
    serial_magnitude_comparator_ctrl #(.WIDTH(4), .EARLY_EXIT(1'b0)) u4n (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4n), .a(a4), .b(b4),
        .out_valid(ov4n), .out_ready(ordy), .lt(lt4n), .gt(gt4n), .eq(eq4n), .busy(bz4n));

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags are {lt,gt,eq}; called just after a falling edge with both 8-bit units idle
    task automatic cmp8(input logic [7:0] av, input logic [7:0] bv, input int lat_x,
                        input logic [2:0] f_x, input string tag);
        int le, ln;
        logic [2:0] fe, fn;
        le = -1; ln = -1; fe = '0; fn = '0;
        a8 = av; b8 = bv; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        chk(bz8e, 1, {tag, " busy_e"});
        chk({ov8e, ir8e}, 0, {tag, " ov/ir_e"});
        for (int c = 1; c <= 20 && (le < 0 || ln < 0); c++) begin
            @(negedge clk);
            if (le < 0 && ov8e) begin le = c; fe = {lt8e, gt8e, eq8e}; end
            if (ln < 0 && ov8n) begin ln = c; fn = {lt8n, gt8n, eq8n}; end
        end
        chk(le, lat_x, {tag, " lat_e"});
        chk(ln, 8, {tag, " lat_n"});
        chk(fe, f_x, {tag, " flags_e"});
        chk(fn, f_x, {tag, " flags_n"});
        @(negedge clk);
    endtask

    task automatic cmp4(input logic [3:0] av, input logic [3:0] bv);
        int le, ln, lat_x;
        logic [2:0] fe, fn, f_x;
        logic [3:0] x;
        string tag;
        tag = $sformatf("w4 %h/%h", av, bv);
        x = av ^ bv;
        lat_x = 4;
        for (int k = 0; k < 4; k++) if (x[k]) lat_x = 4 - k;
        f_x = av < bv ? 3'b100 : av > bv ? 3'b010 : 3'b001;
        le = -1; ln = -1; fe = '0; fn = '0;
        a4 = av; b4 = bv; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        for (int c = 1; c <= 10 && (le < 0 || ln < 0); c++) begin
            @(negedge clk);
            if (le < 0 && ov4e) begin le = c; fe = {lt4e, gt4e, eq4e}; end
            if (ln < 0 && ov4n) begin ln = c; fn = {lt4n, gt4n, eq4n}; end
        end
        chk(le, lat_x, {tag, " lat_e"});
        chk(ln, 4, {tag, " lat_n"});
        chk(fe, f_x, {tag, " flags_e"});
        chk(fn, f_x, {tag, " flags_n"});
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk({ir8e, ir8n, ir4e, ir4n}, 0, "in_ready during rst");
        rst = 1'b0;
        #1;
        chk({ir8e, ov8e, lt8e, gt8e, eq8e, bz8e}, 6'b100000, "reset state 8e");
        chk({ir8n, ov8n, lt8n, gt8n, eq8n, bz8n}, 6'b100000, "reset state 8n");
        chk({ir4e, ov4e, ir4n, ov4n}, 4'b1010, "reset state w4");

        cmp8(8'h80, 8'h7F, 1, 3'b010, "80/7F");
        cmp8(8'h12, 8'h13, 8, 3'b100, "12/13");
        cmp8(8'h05, 8'h05, 8, 3'b001, "05/05");
        cmp8(8'h00, 8'hFF, 1, 3'b100, "00/FF");
        cmp8(8'h3C, 8'h34, 5, 3'b010, "3C/34");
        cmp8(8'h40, 8'h50, 4, 3'b100, "40/50");
        cmp8(8'hFF, 8'hFF, 8, 3'b001, "FF/FF");
        cmp8(8'h00, 8'h00, 8, 3'b001, "00/00");

        // backpressure on the early-exit unit
        ordy = 1'b0;
        a8 = 8'h80; b8 = 8'h7F; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        chk({ov8e, lt8e, gt8e, eq8e}, 4'b1010, "bp done");
        a8 = 8'h00; b8 = 8'hFF; iv8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk({ov8e, lt8e, gt8e, eq8e, ir8e, bz8e}, 6'b101000, $sformatf("bp hold %0d", k));
        end
        ordy = 1'b1;
        @(negedge clk);
        chk({ir8e, ov8e, gt8e}, 3'b101, "bp released");
        @(negedge clk);
        chk({bz8e, ir8e, lt8e, gt8e, eq8e}, 5'b10000, "bp new accept");
        iv8 = 1'b0;
        @(negedge clk);
        chk({ov8e, lt8e, gt8e, eq8e}, 4'b1100, "bp new result");
        repeat (12) @(negedge clk);

        // reset in the third compare cycle
        a8 = 8'h01; b8 = 8'h00; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk({ir8e, ir8n}, 0, "mid rst in_ready");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({ir8e, ov8e, lt8e, gt8e, eq8e, bz8e}, 6'b100000, "mid rst 8e");
        chk({ir8n, ov8n, lt8n, gt8n, eq8n, bz8n}, 6'b100000, "mid rst 8n");
        @(negedge clk);
        chk({ov8e, ov8n}, 0, "no result after rst");
        cmp8(8'h01, 8'h00, 8, 3'b010, "01/00 after rst");

        for (int i = 0; i < 256; i++) cmp4(4'(i >> 4), 4'(i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
